// File: rtl/duck_round_ctrl.sv
// Round sequencer for the duck shooting game: intro, per-duck windows, results, pass/fail.
// Every phase is timed by a 1 ms tick whose counters restart on each state change.
module duck_round_ctrl #(
    parameter int unsigned CLK_HZ          = 65_000_000,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned ROUNDS          = 5,
    parameter int unsigned PASS_HITS       = 6,
    parameter int unsigned INTRO_MS        = 2000,
    parameter int unsigned DUCK_TIMEOUT_MS = 5000,
    parameter int unsigned RESULT_MS       = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] score,
    output logic       game_enable,
    output logic [2:0] round,
    output logic [3:0] duck_idx,
    output logic [3:0] round_hits,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over,
    output logic       game_won
);

    localparam int unsigned TickDiv = CLK_HZ / 1000;
    localparam int unsigned PW      = (TickDiv > 1) ? $clog2(TickDiv) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIntro,
        StDuck,
        StResult,
        StRoundEnd,
        StOver
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic [6:0]    score_q, score_d;
    logic [2:0]    round_q, round_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    hits_q, hits_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          over_q, over_d;
    logic          won_q, won_d;
    logic          enable_q;
    logic          ms_tick;

    assign ms_tick = (presc_q == PW'(TickDiv - 1));

    // A phase of N ms ends on the tick that would bring the ms counter to N.
    function automatic logic phase_done(input logic tick, input logic [15:0] ms,
                                        input int unsigned len);
        return tick && (ms == 16'(len - 1));
    endfunction

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        round_d = round_q;
        idx_d   = idx_q;
        hits_d  = hits_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        over_d  = over_q;
        won_d   = won_q;

        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d = StIntro;
                    round_d = 3'd1;
                    idx_d   = 4'd0;
                    hits_d  = 4'd0;
                    over_d  = 1'b0;
                    won_d   = 1'b0;
                end
            end
            StIntro: begin
                if (phase_done(ms_tick, ms_q, INTRO_MS)) begin
                    state_d = StDuck;
                    score_d = score;
                end
            end
            StDuck: begin
                // A hit takes precedence over a timeout in the same cycle.
                if (score != score_q) begin
                    hit_d   = 1'b1;
                    hits_d  = (hits_q == 4'd15) ? 4'd15 : hits_q + 4'd1;
                    state_d = StResult;
                end else if (phase_done(ms_tick, ms_q, DUCK_TIMEOUT_MS)) begin
                    miss_d  = 1'b1;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (phase_done(ms_tick, ms_q, RESULT_MS)) begin
                    if (idx_q == 4'(DUCKS_PER_ROUND - 1)) begin
                        state_d = StRoundEnd;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        score_d = score;
                        state_d = StDuck;
                    end
                end
            end
            StRoundEnd: begin
                if (hits_q >= 4'(PASS_HITS)) begin
                    if (round_q < 3'(ROUNDS)) begin
                        state_d = StIntro;
                        round_d = round_q + 3'd1;
                        idx_d   = 4'd0;
                        hits_d  = 4'd0;
                    end else begin
                        state_d = StOver;
                        over_d  = 1'b1;
                        won_d   = 1'b1;
                    end
                end else begin
                    state_d = StOver;
                    over_d  = 1'b1;
                    won_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        ms_d    = ms_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (ms_tick) begin
            presc_d = '0;
            ms_d    = ms_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            ms_q     <= '0;
            score_q  <= '0;
            round_q  <= '0;
            idx_q    <= '0;
            hits_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            over_q   <= 1'b0;
            won_q    <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            score_q  <= score_d;
            round_q  <= round_d;
            idx_q    <= idx_d;
            hits_q   <= hits_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            over_q   <= over_d;
            won_q    <= won_d;
            enable_q <= (state_q == StDuck);
        end
    end

    assign game_enable = enable_q;
    assign round       = round_q;
    assign duck_idx    = idx_q;
    assign round_hits  = hits_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign game_over   = over_q;
    assign game_won    = won_q;

endmodule
